hbridge_deadtime: RTL and testbench

- Output stage between the command/protection controller and the H-bridge gate-driver pins.
- Takes the requested TOP/BOT switch pattern (legs 1..4, TOP[i]/BOT[i] = same leg) and guarantees two things: no leg ever has TOP and BOT on together, and a programmable all-off dead time separates any two non-zero patterns.
- Also enforces a minimum on-time and a zero-latency kill path from the filtered error inputs.

---
 rtl/hbridge_deadtime_if.sv | 22 ++
 rtl/hbridge_deadtime.sv | 124 ++++++++++++
 tb/tb_hbridge_deadtime.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbridge_deadtime_if.sv
// Gate-command bundle between the protection controller (master) and the
// H-bridge dead-time output stage (slave).
interface hbridge_deadtime_if;
    logic [3:0] req_top;
    logic [3:0] req_bot;
    logic       kill;
    logic       fault_clr;
    logic [3:0] o_top;
    logic [3:0] o_bot;
    logic       busy;
    logic       fault;

    modport master (
        output req_top, req_bot, kill, fault_clr,
        input  o_top, o_bot, busy, fault
    );

    modport slave (
        input  req_top, req_bot, kill, fault_clr,
        output o_top, o_bot, busy, fault
    );
endinterface

// File: rtl/hbridge_deadtime.sv
// H-bridge output stage: blocks shoot-through, inserts an all-off dead time
// between non-zero patterns, enforces a minimum on-time, and kills combinationally.
module hbridge_deadtime #(
    parameter int unsigned DEADTIME_CYC = 50,
    parameter int unsigned MIN_ON_CYC   = 25,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rstn,
    hbridge_deadtime_if.slave  bus
);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_KILL = 2'd2;

    localparam logic [CNT_W-1:0] DEAD_MAX = CNT_W'(DEADTIME_CYC);
    localparam logic [CNT_W-1:0] ON_MAX   = CNT_W'(MIN_ON_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       applied_top_q, applied_top_d;
    logic [3:0]       applied_bot_q, applied_bot_d;
    logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
    logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
    logic             fault_q, fault_d;

    logic             illegal;
    logic             req_nz;
    logic             req_diff;
    logic [CNT_W-1:0] off_cnt_inc;
    logic [CNT_W-1:0] on_cnt_inc;
    logic             drive_en;
    logic [3:0]       o_top_w;
    logic [3:0]       o_bot_w;

    // A shoot-through request is never driven; it only ever forces the stage off.
    assign illegal  = |(bus.req_top & bus.req_bot);
    assign req_nz   = |{bus.req_top, bus.req_bot};
    assign req_diff = ({bus.req_top, bus.req_bot} != {applied_top_q, applied_bot_q});

    assign off_cnt_inc = (off_cnt_q >= DEAD_MAX) ? DEAD_MAX : off_cnt_q + CNT_ONE;
    assign on_cnt_inc  = (on_cnt_q  >= ON_MAX)   ? ON_MAX   : on_cnt_q  + CNT_ONE;

    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d       = state_q;
        applied_top_d = applied_top_q;
        applied_bot_d = applied_bot_q;
        off_cnt_d     = off_cnt_q;
        on_cnt_d      = on_cnt_q;

        case (state_q)
            ST_OFF: begin
                off_cnt_d = off_cnt_inc;
                if (bus.kill) begin
                    state_d = ST_KILL;
                end else if (!illegal && req_nz && off_cnt_q == DEAD_MAX) begin
                    state_d       = ST_ON;
                    applied_top_d = bus.req_top;
                    applied_bot_d = bus.req_bot;
                    on_cnt_d      = CNT_ONE;
                end
            end
            ST_ON: begin
                on_cnt_d = on_cnt_inc;
                if (bus.kill) begin
                    state_d   = ST_KILL;
                    off_cnt_d = CNT_ONE;
                end else if (illegal || (req_diff && on_cnt_q == ON_MAX)) begin
                    state_d   = ST_OFF;
                    off_cnt_d = CNT_ONE;
                end
            end
            ST_KILL: begin
                // Time spent killed counts toward the dead time.
                off_cnt_d     = off_cnt_inc;
                applied_top_d = 4'b0000;
                applied_bot_d = 4'b0000;
                if (!bus.kill) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d       = ST_OFF;
                applied_top_d = 4'b0000;
                applied_bot_d = 4'b0000;
            end
        endcase
    end

    // A new illegal request beats a simultaneous clear.
    assign fault_d = illegal | (fault_q & ~bus.fault_clr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_OFF;
            applied_top_q <= 4'b0000;
            applied_bot_q <= 4'b0000;
            off_cnt_q     <= '0;
            on_cnt_q      <= '0;
            fault_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q       <= state_d;
            applied_top_q <= applied_top_d;
            applied_bot_q <= applied_bot_d;
            off_cnt_q     <= off_cnt_d;
            on_cnt_q      <= on_cnt_d;
            fault_q       <= fault_d;
        end
    end

    // Kill gates the pins directly so the bridge opens in the same cycle.
    assign drive_en = (state_q == ST_ON) & ~bus.kill;
    assign o_top_w  = applied_top_q & {4{drive_en}};
    assign o_bot_w  = applied_bot_q & {4{drive_en}};

    assign bus.o_top = o_top_w;
    assign bus.o_bot = o_bot_w;
    assign bus.busy  = ({bus.req_top, bus.req_bot} != {o_top_w, o_bot_w}) & ~bus.kill & ~illegal;
    assign bus.fault = fault_q;

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Self-checking bench for hbridge_deadtime: directed scenarios plus random
// traffic against a behavioural pattern/dead-time model.
module tb_hbridge_deadtime;

    localparam int DT  = 4;
    localparam int MIN = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    hbridge_deadtime_if dif ();

    hbridge_deadtime #(
        .DEADTIME_CYC(DT),
        .MIN_ON_CYC  (MIN),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: the pattern on the pins, how long the bridge has been
    // fully off, how long the current pattern has been held, and whether a kill
    // is still being served.
    logic [7:0] m_pat;
    int         m_dead;
    int         m_held;
    bit         m_kill;
    bit         m_fault;

    task automatic model_reset();
        m_pat   = 8'h00;
        m_dead  = 0;
        m_held  = 0;
        m_kill  = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] req;
        bit         ill;
        int         dead_prev;
        int         held_prev;
        req       = {dif.req_top, dif.req_bot};
        ill       = |(dif.req_top & dif.req_bot);
        dead_prev = m_dead;
        held_prev = m_held;
        m_fault   = ill || (m_fault && !dif.fault_clr);
        if (m_kill) begin
            m_dead = (m_dead >= DT) ? DT : m_dead + 1;
            m_pat  = 8'h00;
            if (!dif.kill) m_kill = 1'b0;
        end else if (m_pat == 8'h00) begin
            m_dead = (m_dead >= DT) ? DT : m_dead + 1;
            if (dif.kill) begin
                m_kill = 1'b1;
            end else if (!ill && req != 8'h00 && dead_prev == DT) begin
                m_pat  = req;
                m_held = 1;
            end
        end else begin
            m_held = (m_held >= MIN) ? MIN : m_held + 1;
            if (dif.kill) begin
                m_kill = 1'b1;
                m_pat  = 8'h00;
                m_dead = 1;
            end else if (ill || (req != m_pat && held_prev == MIN)) begin
                m_pat  = 8'h00;
                m_dead = 1;
            end
        end
    endtask

    // {o_top, o_bot, busy, fault} as the model predicts them right now.
    function automatic logic [9:0] exp_vec();
        logic [7:0] o;
        logic       ill;
        logic       bsy;
        ill = |(dif.req_top & dif.req_bot);
        o   = dif.kill ? 8'h00 : m_pat;
        bsy = ({dif.req_top, dif.req_bot} != o) && !dif.kill && !ill;
        return {o, bsy, m_fault};
    endfunction

    function automatic logic [9:0] act_vec();
        return {dif.o_top, dif.o_bot, dif.busy, dif.fault};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input logic [3:0] t, input logic [3:0] b);
        dif.req_top = t;
        dif.req_bot = b;
    endtask

    // Independent pin-level invariants: no leg shoot-through, and every
    // non-zero pattern is preceded by at least DT all-off cycles.
    int         mon_zrun = 0;
    logic [7:0] mon_prev = 8'h00;
    always @(negedge clk) begin
        if (!rstn) begin
            mon_zrun = 0;
            mon_prev = 8'h00;
        end else begin
            checks++;
            if ((dif.o_top & dif.o_bot) !== 4'b0000) begin
                errors++;
                $display("FAIL shoot_through t=%0t: top=%b bot=%b overlap required 0000",
                         $time, dif.o_top, dif.o_bot);
            end
            if ({dif.o_top, dif.o_bot} != 8'h00 && mon_prev == 8'h00) begin
                checks++;
                if (mon_zrun < DT) begin
                    errors++;
                    $display("FAIL dead_gap t=%0t: got %0d off cycles, required >= %0d",
                             $time, mon_zrun, DT);
                end
            end
            if ({dif.o_top, dif.o_bot} == 8'h00) mon_zrun++;
            else mon_zrun = 0;
            mon_prev = {dif.o_top, dif.o_bot};
        end
    end

    task automatic test_reset();
        int first_nz;
        set_req(4'b0000, 4'b0000);
        dif.kill      = 1'b0;
        dif.fault_clr = 1'b0;
        rstn          = 1'b0;
        model_reset();
        #17;
        checks++;
        if (act_vec() !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got %b required %b", act_vec(), 10'b0);
        end
        set_req(4'b0001, 4'b0010);
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        first_nz = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_release cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            if (first_nz < 0 && {dif.o_top, dif.o_bot} != 8'h00) first_nz = i;
            step();
        end
        checks++;
        if (first_nz != DT + 1) begin
            errors++;
            $display("FAIL reset_first_on: got cycle %0d required %0d", first_nz, DT + 1);
        end
    endtask

    task automatic test_change();
        int zeros;
        zeros = 0;
        set_req(4'b0010, 4'b0001);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL change cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            if ({dif.o_top, dif.o_bot} == 8'h00) zeros++;
            step();
        end
        checks++;
        if (zeros != DT || {dif.o_top, dif.o_bot} !== 8'b0010_0001) begin
            errors++;
            $display("FAIL change_gap: got %0d zeros, pins %b; required %0d zeros, pins 00100001",
                     zeros, {dif.o_top, dif.o_bot}, DT);
        end
    endtask

    task automatic test_early_change();
        int a_cnt;
        int zeros;
        bit seen;
        set_req(4'b0000, 4'b0000);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL early_idle cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            step();
        end
        set_req(4'b0001, 4'b0010);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL early_apply cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            if ({dif.o_top, dif.o_bot} == 8'b0001_0010) seen = 1'b1;
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL early_apply_timeout: got no 00010010 on pins, required it within 10 cycles");
        end
        set_req(4'b0100, 4'b1000);
        a_cnt = 0;
        zeros = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL early_change cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            if ({dif.o_top, dif.o_bot} == 8'b0001_0010) a_cnt++;
            if ({dif.o_top, dif.o_bot} == 8'h00) zeros++;
            step();
        end
        checks++;
        if (a_cnt != MIN - 1 || zeros != DT) begin
            errors++;
            $display("FAIL early_hold: got hold %0d zeros %0d, required hold %0d zeros %0d",
                     a_cnt, zeros, MIN - 1, DT);
        end
    endtask

    task automatic test_kill();
        bit back;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL kill_pre cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            step();
        end
        dif.kill = 1'b1;
        #1;
        checks++;
        if ({dif.o_top, dif.o_bot, dif.busy} !== 9'b0) begin
            errors++;
            $display("FAIL kill_immediate: got pins/busy %b required all zero",
                     {dif.o_top, dif.o_bot, dif.busy});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL kill_hold cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            step();
        end
        dif.kill = 1'b0;
        back     = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL kill_release cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            if ({dif.o_top, dif.o_bot} == 8'b0100_1000) back = 1'b1;
            step();
        end
        checks++;
        if (!back) begin
            errors++;
            $display("FAIL kill_resume: got no 01001000 after release, required it within 6 cycles");
        end
    endtask

    typedef struct {
        logic [3:0] top;
        logic [3:0] bot;
        logic       clr;
        logic       exp_fault;
    } fault_row_t;

    task automatic test_illegal();
        fault_row_t rows [9];
        rows[0] = '{4'b0001, 4'b0001, 1'b0, 1'b0};
        rows[1] = '{4'b0100, 4'b1000, 1'b0, 1'b1};
        rows[2] = '{4'b0100, 4'b1000, 1'b0, 1'b1};
        rows[3] = '{4'b0100, 4'b1000, 1'b1, 1'b1};
        rows[4] = '{4'b0100, 4'b1000, 1'b0, 1'b0};
        rows[5] = '{4'b0001, 4'b0001, 1'b1, 1'b0};
        rows[6] = '{4'b0100, 4'b1000, 1'b0, 1'b1};
        rows[7] = '{4'b0100, 4'b1000, 1'b1, 1'b1};
        rows[8] = '{4'b0100, 4'b1000, 1'b0, 1'b0};
        for (int i = 0; i < 9; i++) begin
            set_req(rows[i].top, rows[i].bot);
            dif.fault_clr = rows[i].clr;
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL illegal cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            checks++;
            if (dif.fault !== rows[i].exp_fault) begin
                errors++;
                $display("FAIL fault_flag cyc %0d: got %b required %b", i, dif.fault, rows[i].exp_fault);
            end
            if (i == 1) begin
                checks++;
                if ({dif.o_top, dif.o_bot} !== 8'h00) begin
                    errors++;
                    $display("FAIL illegal_off: got %b required 00000000", {dif.o_top, dif.o_bot});
                end
            end
            step();
        end
        dif.fault_clr = 1'b0;
    endtask

    task automatic test_zero_req();
        int zeros;
        set_req(4'b0001, 4'b0010);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL zero_pre cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            step();
        end
        set_req(4'b0000, 4'b0000);
        zeros = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) set_req(4'b0010, 4'b0001);
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL zero_req cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            if (i == 1) begin
                checks++;
                if ({dif.o_top, dif.o_bot, dif.busy} !== 9'b0) begin
                    errors++;
                    $display("FAIL zero_idle: got pins/busy %b required all zero",
                             {dif.o_top, dif.o_bot, dif.busy});
                end
            end
            if ({dif.o_top, dif.o_bot} == 8'h00) zeros++;
            step();
        end
        checks++;
        if (zeros != DT || {dif.o_top, dif.o_bot} !== 8'b0010_0001) begin
            errors++;
            $display("FAIL zero_gap: got %0d zeros, pins %b; required %0d zeros, pins 00100001",
                     zeros, {dif.o_top, dif.o_bot}, DT);
        end
    endtask

    task automatic test_async_reset();
        int first_nz;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({dif.o_top, dif.o_bot, dif.fault} !== 9'b0) begin
            errors++;
            $display("FAIL async_reset: got pins/fault %b required all zero",
                     {dif.o_top, dif.o_bot, dif.fault});
        end
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        first_nz = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL async_release cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            if (first_nz < 0 && {dif.o_top, dif.o_bot} != 8'h00) first_nz = i;
            step();
        end
        checks++;
        if (first_nz != DT + 1) begin
            errors++;
            $display("FAIL async_first_on: got cycle %0d required %0d", first_nz, DT + 1);
        end
    endtask

    task automatic test_random();
        logic [3:0] t;
        logic [3:0] b;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                t = 4'($urandom);
                case ($urandom_range(0, 9))
                    0:       b = 4'($urandom) | t;
                    1:       begin t = 4'b0000; b = 4'b0000; end
                    default: b = 4'($urandom) & ~t;
                endcase
                if (t != 4'b0000 && (t & b) == 4'b0000 && $urandom_range(0, 9) == 0) b = t;
                set_req(t, b);
            end
            if ($urandom_range(0, 29) == 0) dif.kill = ~dif.kill;
            dif.fault_clr = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %b required %b", i, act_vec(), exp_vec());
            end
            step();
        end
        dif.kill      = 1'b0;
        dif.fault_clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, required finish within 300000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_change();
        test_early_change();
        test_kill();
        test_illegal();
        test_zero_req();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
